// File: rtl/cim_mac_sequencer.sv
// Column-by-column sequencer for the compute-in-memory MAC macro.
// Each column runs SETUP -> COMPUTE -> REPORT; all outputs are registered from the next state.
module cim_mac_sequencer #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned MAC_CYC   = 2
) (
  input  logic        clk_inv,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_col_start,
  input  logic [3:0]  cmd_col_count,
  input  logic [15:0] cmd_data,
  input  logic        abort,
  output logic        mac_en,
  output logic [7:0]  col_mux,
  output logic [15:0] data_in,
  output logic        res_valid,
  output logic [2:0]  res_col,
  output logic        done,
  output logic        cmd_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, COMPUTE, REPORT} state_e;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] MAC_LD   = 4'(MAC_CYC - 1);

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  remain_q, remain_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        err_d;
  logic        cmd_legal;

  logic        mac_en_q, res_valid_q, done_q, cmd_err_q, busy_q;
  logic [7:0]  col_mux_q;
  logic [2:0]  res_col_q;
  logic [7:0]  col_sel;

  assign cmd_legal = (cmd_col_count != 4'd0) && (cmd_col_count <= 4'd8);

  // One-hot decode of the column the next cycle will drive.
  for (genvar gi = 0; gi < 8; gi++) begin : g_col
    assign col_sel[gi] = (ptr_d == 3'(gi));
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal) begin
            data_d   = cmd_data;
            ptr_d    = cmd_col_start;
            remain_d = cmd_col_count;
            cnt_d    = SETUP_LD;
            state_d  = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = MAC_LD;
          state_d = COMPUTE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      COMPUTE: begin
        if (cnt_q == 4'd0) begin
          state_d = REPORT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REPORT: begin
        remain_d = remain_q - 4'd1;
        ptr_d    = ptr_q + 3'd1;
        cnt_d    = SETUP_LD;
        state_d  = (remain_q == 4'd1) ? IDLE : SETUP;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over every other transition of a running command.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_inv or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      remain_q    <= 4'd0;
      cnt_q       <= 4'd0;
      data_q      <= 16'd0;
      mac_en_q    <= 1'b1;
      col_mux_q   <= 8'd0;
      res_valid_q <= 1'b0;
      res_col_q   <= 3'd0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      mac_en_q    <= (state_d != COMPUTE);
      col_mux_q   <= (state_d == IDLE) ? 8'd0 : col_sel;
      res_valid_q <= (state_d == REPORT);
      res_col_q   <= (state_d == REPORT) ? ptr_d : res_col_q;
      done_q      <= (state_d == REPORT) && (remain_q == 4'd1);
      cmd_err_q   <= err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign mac_en    = mac_en_q;
  assign col_mux   = col_mux_q;
  assign data_in   = data_q;
  assign res_valid = res_valid_q;
  assign res_col   = res_col_q;
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cim_mac_sequencer.sv
// Bench for cim_mac_sequencer: directed table, hand-written reset sequence and random commands
// checked cycle by cycle against a trace built from the column timing rules.
module tb_cim_mac_sequencer;

  logic        clk_inv = 1'b0;
  logic        rst_n;
  logic        cmd_valid, abort, use2;
  logic [2:0]  cmd_col_start;
  logic [3:0]  cmd_col_count;
  logic [15:0] cmd_data;

  logic        a_ready, a_mac_en, a_res_valid, a_done, a_err, a_busy;
  logic [7:0]  a_col_mux;
  logic [15:0] a_data;
  logic [2:0]  a_res_col;
  logic        b_ready, b_mac_en, b_res_valid, b_done, b_err, b_busy;
  logic [7:0]  b_col_mux;
  logic [15:0] b_data;
  logic [2:0]  b_res_col;

  always #5 clk_inv = ~clk_inv;

  cim_mac_sequencer dut_a (
    .clk_inv(clk_inv), .rst_n(rst_n), .cmd_valid(cmd_valid & ~use2), .cmd_ready(a_ready),
    .cmd_col_start(cmd_col_start), .cmd_col_count(cmd_col_count), .cmd_data(cmd_data),
    .abort(abort & ~use2), .mac_en(a_mac_en), .col_mux(a_col_mux), .data_in(a_data),
    .res_valid(a_res_valid), .res_col(a_res_col), .done(a_done), .cmd_err(a_err), .busy(a_busy)
  );

  cim_mac_sequencer #(.SETUP_CYC(3), .MAC_CYC(5)) dut_b (
    .clk_inv(clk_inv), .rst_n(rst_n), .cmd_valid(cmd_valid & use2), .cmd_ready(b_ready),
    .cmd_col_start(cmd_col_start), .cmd_col_count(cmd_col_count), .cmd_data(cmd_data),
    .abort(abort & use2), .mac_en(b_mac_en), .col_mux(b_col_mux), .data_in(b_data),
    .res_valid(b_res_valid), .res_col(b_res_col), .done(b_done), .cmd_err(b_err), .busy(b_busy)
  );

  logic        o_ready, o_mac_en, o_res_valid, o_done, o_err, o_busy;
  logic [7:0]  o_col_mux;
  logic [15:0] o_data;
  logic [2:0]  o_res_col;
  assign o_ready     = use2 ? b_ready     : a_ready;
  assign o_mac_en    = use2 ? b_mac_en    : a_mac_en;
  assign o_res_valid = use2 ? b_res_valid : a_res_valid;
  assign o_done      = use2 ? b_done      : a_done;
  assign o_err       = use2 ? b_err       : a_err;
  assign o_busy      = use2 ? b_busy      : a_busy;
  assign o_col_mux   = use2 ? b_col_mux   : a_col_mux;
  assign o_data      = use2 ? b_data      : a_data;
  assign o_res_col   = use2 ? b_res_col   : a_res_col;

  logic [13:0] obs_vec;
  assign obs_vec = {o_mac_en, o_col_mux, o_res_valid, o_done, o_busy, o_ready, o_err};

  int total = 0;
  int bad   = 0;
  logic [15:0] dm [2];

  typedef struct {
    logic [13:0] vec;
    logic [2:0]  col;
  } exp_t;
  exp_t trace_q[$];

  typedef struct {
    logic        sel;
    logic [2:0]  st;
    logic [3:0]  cnt;
    logic [15:0] d;
    int          ab_at;
    int          e_res, e_done, e_err, e_busy;
    logic [2:0]  e_last;
  } vec_t;

  function automatic logic [13:0] mkvec(logic me, logic [7:0] cm, logic rv, logic dn,
                                         logic bz, logic rdy, logic er);
    return {me, cm, rv, dn, bz, rdy, er};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_inv);
    #1;
  endtask

  // Expected per-cycle trace of a legal command, from the column timing rules.
  task automatic build_trace(input logic [2:0] st, input logic [3:0] cnt, input int s, input int m);
    exp_t e;
    logic [7:0] oh;
    trace_q.delete();
    for (int k = 0; k < int'(cnt); k++) begin
      e.col = 3'((int'(st) + k) % 8);
      oh = 8'd1;
      oh = oh << e.col;
      for (int i = 0; i < s; i++) begin
        e.vec = mkvec(1'b1, oh, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        trace_q.push_back(e);
      end
      for (int i = 0; i < m; i++) begin
        e.vec = mkvec(1'b0, oh, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        trace_q.push_back(e);
      end
      e.vec = mkvec(1'b1, oh, 1'b1, (k == int'(cnt) - 1), 1'b1, 1'b0, 1'b0);
      trace_q.push_back(e);
    end
  endtask

  task automatic run_cmd(input logic [2:0] st, input logic [3:0] cnt, input logic [15:0] d,
                         input int ab_at, output int n_res, output int n_done,
                         output int n_err, output int n_busy, output logic [2:0] last_col);
    int s, m, sel;
    logic legal;
    logic [13:0] idle_v;
    sel    = use2 ? 1 : 0;
    s      = use2 ? 3 : 1;
    m      = use2 ? 5 : 2;
    legal  = (cnt >= 4'd1) && (cnt <= 4'd8);
    idle_v = mkvec(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_res = 0; n_done = 0; n_err = 0; n_busy = 0; last_col = 3'd0;
    chk("ready_before_cmd", {31'd0, o_ready}, 32'd1);
    cmd_col_start = st;
    cmd_col_count = cnt;
    cmd_data      = d;
    cmd_valid     = 1'b1;
    step();
    cmd_valid = 1'b0;
    if (!legal) begin
      n_err += int'(o_err);
      chk("reject_cycle", {18'd0, obs_vec}, {18'd0, mkvec(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)});
      chk("reject_data_kept", {16'd0, o_data}, {16'd0, dm[sel]});
      step();
      n_err += int'(o_err);
      chk("after_reject", {18'd0, obs_vec}, {18'd0, idle_v});
    end else begin
      dm[sel] = d;
      build_trace(st, cnt, s, m);
      for (int i = 0; i < trace_q.size(); i++) begin
        n_res  += int'(o_res_valid);
        n_done += int'(o_done);
        n_busy += int'(o_busy);
        if (o_res_valid) last_col = o_res_col;
        chk($sformatf("trace[%0d]", i), {18'd0, obs_vec}, {18'd0, trace_q[i].vec});
        if (trace_q[i].vec[4]) chk($sformatf("res_col[%0d]", i), {29'd0, o_res_col}, {29'd0, trace_q[i].col});
        chk($sformatf("data_in[%0d]", i), {16'd0, o_data}, {16'd0, d});
        if (i == ab_at) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          break;
        end
        step();
      end
      n_res  += int'(o_res_valid);
      n_done += int'(o_done);
      n_busy += int'(o_busy);
      chk("idle_after_cmd", {18'd0, obs_vec}, {18'd0, idle_v});
      chk("data_after_cmd", {16'd0, o_data}, {16'd0, d});
    end
  endtask

  vec_t tbl[$];

  initial begin
    int nr, nd, ne, nb, ab, per, len;
    logic [2:0] lc;
    logic [2:0] rst_v;
    logic [3:0] rcnt;
    vec_t v;

    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; use2 = 1'b0;
    cmd_col_start = 3'd0; cmd_col_count = 4'd0; cmd_data = 16'd0;
    dm[0] = 16'd0; dm[1] = 16'd0;

    // sel, start, count, data, abort index, res pulses, dones, errs, busy cycles, last res_col
    tbl.push_back('{1'b0, 3'd2, 4'd1, 16'hA5C3, -1, 1, 1, 0, 4,  3'd2});
    tbl.push_back('{1'b0, 3'd6, 4'd4, 16'h1234, -1, 4, 1, 0, 16, 3'd1});
    tbl.push_back('{1'b0, 3'd0, 4'd0, 16'hDEAD, -1, 0, 0, 1, 0,  3'd0});
    tbl.push_back('{1'b0, 3'd3, 4'd9, 16'hBEEF, -1, 0, 0, 1, 0,  3'd0});
    tbl.push_back('{1'b0, 3'd0, 4'd8, 16'h0F0F, 14, 3, 0, 0, 15, 3'd2});
    tbl.push_back('{1'b0, 3'd7, 4'd8, 16'hFFFF, -1, 8, 1, 0, 32, 3'd6});
    tbl.push_back('{1'b0, 3'd5, 4'd1, 16'h7777, 0,  0, 0, 0, 1,  3'd0});
    tbl.push_back('{1'b1, 3'd3, 4'd2, 16'h5A5A, -1, 2, 1, 0, 18, 3'd4});
    tbl.push_back('{1'b1, 3'd7, 4'd3, 16'h3C3C, -1, 3, 1, 0, 27, 3'd1});
    tbl.push_back('{1'b1, 3'd1, 4'd15, 16'h9999, -1, 0, 0, 1, 0, 3'd0});

    repeat (3) @(posedge clk_inv);
    #1;
    chk("reset_outputs", {18'd0, obs_vec}, {18'd0, mkvec(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)});
    chk("reset_data_in", {16'd0, o_data}, 32'd0);
    chk("reset_res_col", {29'd0, o_res_col}, 32'd0);
    rst_n = 1'b1;
    step();

    foreach (tbl[t]) begin
      v = tbl[t];
      use2 = v.sel;
      run_cmd(v.st, v.cnt, v.d, v.ab_at, nr, nd, ne, nb, lc);
      $display("vec %0d: sel=%0d start=%0d count=%0d res=%0d done=%0d err=%0d busy=%0d",
               t, v.sel, v.st, v.cnt, nr, nd, ne, nb);
      chk($sformatf("vec%0d_res", t), nr, v.e_res);
      chk($sformatf("vec%0d_done", t), nd, v.e_done);
      chk($sformatf("vec%0d_err", t), ne, v.e_err);
      chk($sformatf("vec%0d_busy", t), nb, v.e_busy);
      if (v.e_res > 0) chk($sformatf("vec%0d_last_col", t), {29'd0, lc}, {29'd0, v.e_last});
    end

    // Asynchronous reset in the middle of COMPUTE.
    use2 = 1'b0;
    cmd_col_start = 3'd1; cmd_col_count = 4'd3; cmd_data = 16'hC0DE;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("pre_reset_mac_en", {31'd0, o_mac_en}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mac_en", {31'd0, o_mac_en}, 32'd1);
    chk("async_col_mux", {24'd0, o_col_mux}, 32'd0);
    chk("async_busy", {31'd0, o_busy}, 32'd0);
    chk("async_data_in", {16'd0, o_data}, 32'd0);
    $display("async reset: mac_en=%0d col_mux=%0h busy=%0d", o_mac_en, o_col_mux, o_busy);
    dm[0] = 16'd0; dm[1] = 16'd0;
    #2 rst_n = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, o_ready}, 32'd1);

    for (int r = 0; r < 45; r++) begin
      use2  = (r >= 32);
      per   = use2 ? 9 : 4;
      rst_v = 3'($urandom_range(0, 7));
      rcnt  = 4'($urandom_range(0, 10));
      ab    = -1;
      len   = int'(rcnt) * per;
      if (rcnt >= 4'd1 && rcnt <= 4'd8 && $urandom_range(0, 3) == 0) begin
        ab = $urandom_range(0, len - 1);
        if (ab % per == per - 1) ab = ab - 1;
      end
      run_cmd(rst_v, rcnt, 16'($urandom), ab, nr, nd, ne, nb, lc);
      $display("rand %0d: sel=%0d start=%0d count=%0d abort_at=%0d res=%0d done=%0d err=%0d",
               r, use2, rst_v, rcnt, ab, nr, nd, ne);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cim_mac_sequencer.md
# cim_mac_sequencer

Command-driven controller that sequences the compute-in-memory MAC macro column by column. It accepts a command (start column, column count, 16-bit input word) over a valid/ready handshake. For each column it drives the one-hot `col_mux`, the active-low `mac_en` strobe and the held `data_in` word through a setup/compute/report sequence. Its outputs feed the negedge re-timing stage in front of the macro.

## Interface
- `SETUP_CYC`, default 1: cycles `col_mux` is stable with `mac_en` high before compute (1..15).
- `MAC_CYC`, default 2: cycles `mac_en` is held low per column (1..15).
- `clk_inv`, input, 1: block clock; every register updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: high only in IDLE.
- `cmd_col_start`, input, 3: first column index (0..7).
- `cmd_col_count`, input, 4: number of columns (legal range 1..8).
- `cmd_data`, input, 16: input word applied for the whole command.
- `abort`, input, 1: synchronous abort of the running command.
- `mac_en`, output, 1: MAC strobe, active-low (1 = idle).
- `col_mux`, output, 8: one-hot column select; all zero when idle.
- `data_in`, output, 16: latched `cmd_data`.
- `res_valid`, output, 1: one-cycle pulse when a column's MAC has completed.
- `res_col`, output, 3: column index qualified by `res_valid`.
- `done`, output, 1: one-cycle pulse when a command has finished normally.
- `cmd_err`, output, 1: one-cycle pulse when an illegal command is rejected.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, SETUP, COMPUTE, REPORT.
- **Reset values:** state IDLE, `mac_en`=1, `col_mux`=0, `data_in`=0, `res_col`=0; `res_valid`, `done`, `cmd_err`, `busy` all 0; `cmd_ready`=1.
- **IDLE, command accepted** (`cmd_valid` & `cmd_ready`):
  - Legal `cmd_col_count` (1..8): latch `cmd_data` into `data_in`; load the column pointer from `cmd_col_start` and the remaining count from `cmd_col_count`; go to SETUP.
  - `cmd_col_count` 0 or 9..15: stay in IDLE, pulse `cmd_err` in the next cycle, leave `data_in` unchanged.
- **SETUP:**
  - `col_mux` = 1 << pointer; `mac_en`=1.
  - Lasts `SETUP_CYC` cycles, then go to COMPUTE.
- **COMPUTE:**
  - `col_mux` held; `mac_en`=0.
  - Lasts `MAC_CYC` cycles, then go to REPORT.
- **REPORT:** one cycle.
  - `mac_en`=1, `col_mux` held, `res_valid`=1, `res_col` = pointer.
  - Decrement the remaining count. Advance the pointer modulo 8, so index 7 wraps to 0.
  - Remaining count now nonzero: go to SETUP.
  - Remaining count now zero: pulse `done` in this same cycle and go to IDLE.
- **Abort:** `abort` in SETUP, COMPUTE or REPORT moves to IDLE on the next edge.
  - Takes priority over every other transition.
  - No `res_valid` and no `done` are produced in the abort cycle.
  - `data_in` keeps its value.
  - In IDLE, `abort` is ignored.
- `data_in` changes only on accepted legal commands. It is stable for the whole command.
- Per-phase cycle counter width is 4 bits and is reloaded at every state entry.

## Timing
- Acceptance at edge N: `busy`=1, `cmd_ready`=0, and SETUP outputs are visible from N+1.
- Column k (0-based) starts SETUP at N+1+k·(SETUP_CYC+MAC_CYC+1).
- `mac_en` low window per column is exactly `MAC_CYC` cycles, with no gap inside the window.
- `mac_en` is always high for at least `SETUP_CYC`+1 cycles between columns.
- A command of C columns occupies C·(SETUP_CYC+MAC_CYC+1) cycles.
- `done` coincides with the last `res_valid`. `cmd_ready` returns the cycle after.
- Back-to-back commands: the earliest next acceptance is the first IDLE cycle, so there is one idle cycle between commands.
- `cmd_err` is asserted in the cycle after the rejected handshake.
- `rst_n` low at any point forces all reset values immediately (asynchronous), including mid-COMPUTE: `mac_en` rises and `col_mux` clears without waiting for a clock edge.
- Every output is registered, with no combinational path from inputs to outputs. Exception: `cmd_ready` is a decode of the state register.

## Test plan
- **Reset behaviour:** assert reset mid-run -> `mac_en`=1, `col_mux`=0x00, `busy`=0 asynchronously; after release, `cmd_ready`=1.
- **Single column:** defaults, command start=2, count=1, data=0xA5C3 -> `col_mux`=0x04 for 4 cycles; `mac_en` low for cycles 2–3 of that window; `res_valid` with `res_col`=2 and `done` on cycle 4; `data_in`=0xA5C3.
- **Wrap-around:** start=6, count=4 -> `res_col` sequence 6, 7, 0, 1; `col_mux` sequence 0x40, 0x80, 0x01, 0x02; 16 busy cycles; exactly one `done`.
- **Illegal count:** count=0, then count=9 -> one `cmd_err` pulse each; `busy` stays 0; no `mac_en` activity; `data_in` unchanged.
- **Abort:** start=0, count=8, `abort` raised in the 2nd COMPUTE cycle of column 3 -> IDLE on the next edge; `mac_en`=1, `col_mux`=0; only 3 `res_valid` pulses; no `done`. A new command is accepted next cycle.
- **Parameter sweep:** SETUP_CYC=3, MAC_CYC=5, count=2 -> `mac_en` low windows of exactly 5 cycles, separated by 4 high cycles; `done` 18 cycles after acceptance.
